// File: rtl/axil_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_wb_pkg
//  Purpose  : Shared types and helpers for the Wishbone <-> AXI4-lite bridges.
//             AXI response codes, bridge FSM state type, timer width and a
//             constant-foldable ceil(log2) helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package axil_wb_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WB_RESP = 3'd2,
        ST_RD      = 3'd3,
        ST_RD_RESP = 3'd4
    } wbsp2axil_state_t;

    localparam int C_TIMER_WIDTH = 8;

    // ceil(log2(value)); CLOG2(1) = 0
    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbsp2axil_if.sv
`default_nettype none
// ============================================================================
//  Module   : wbsp2axil_wb_if / wbsp2axil_axil_if
//  Purpose  : Bus bundles for the WB-pipelined to AXI4-lite bridge.
//  Ports    : wbsp2axil_wb_if   - cyc/stb/we/addr/wdata/sel (master->slave),
//                                 stall/ack/err/rdata (slave->master)
//             wbsp2axil_axil_if - AW/W/B/AR/R channels of AXI4-lite
//  Revision : 1.0  initial release
// ============================================================================
interface wbsp2axil_wb_if #(
    parameter int AW = 28,
    parameter int DW = 8
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   sel;
    logic              stall;
    logic              ack;
    logic              err;
    logic [DW-1:0]     rdata;

    modport master (output cyc, stb, we, addr, wdata, sel,
                    input  stall, ack, err, rdata);
    modport slave  (input  cyc, stb, we, addr, wdata, sel,
                    output stall, ack, err, rdata);
endinterface

interface wbsp2axil_axil_if #(
    parameter int AW = 28,
    parameter int DW = 32
);
    logic              awvalid;
    logic              awready;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;

    modport master (output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
                           arvalid, araddr, arprot, rready,
                    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
    modport slave  (input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
                           arvalid, araddr, arprot, rready,
                    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
endinterface
`default_nettype wire

// File: rtl/wbsp2axil_lane.sv
`default_nettype none
// ============================================================================
//  Module   : wbsp2axil_lane
//  Purpose  : Combinational byte-lane steering between a narrow WB data path
//             and a wider AXI data path.
//  Ports    : wr_lane, wb_wdata, wb_sel -> axi_wdata (replicated), axi_wstrb
//             rd_lane, axi_rdata        -> wb_rdata (extracted lane)
//  Revision : 1.0  initial release
// ============================================================================
module wbsp2axil_lane #(
    parameter int AXI_DW = 32,
    parameter int WB_DW  = 8,
    parameter int SEL_W  = 1,
    parameter int LANE_W = 2
) (
    input  wire logic [LANE_W-1:0]   wr_lane,
    input  wire logic [WB_DW-1:0]    wb_wdata,
    input  wire logic [SEL_W-1:0]    wb_sel,
    output logic      [AXI_DW-1:0]   axi_wdata,
    output logic      [AXI_DW/8-1:0] axi_wstrb,
    input  wire logic [LANE_W-1:0]   rd_lane,
    input  wire logic [AXI_DW-1:0]   axi_rdata,
    output logic      [WB_DW-1:0]    wb_rdata
);
    localparam int c_REPS   = AXI_DW / WB_DW;
    localparam int c_STRB_W = AXI_DW / 8;

    // Replicating the write data means every lane already holds the right
    // bytes; the strobes alone pick the lane the slave commits.
    generate
        for (genvar g = 0; g < c_REPS; g++) begin : g_rep
            assign axi_wdata[g*WB_DW +: WB_DW] = wb_wdata;
        end
    endgenerate

    assign axi_wstrb = c_STRB_W'(wb_sel) << wr_lane;
    assign wb_rdata  = WB_DW'(axi_rdata >> {rd_lane, 3'b000});

endmodule
`default_nettype wire

// File: rtl/wbsp2axil.sv
`default_nettype none
// ============================================================================
//  Module   : wbsp2axil
//  Purpose  : Wishbone B4 pipelined slave to AXI4-lite master bridge. One
//             transaction outstanding; narrow WB data steered onto AXI byte
//             lanes; a response timeout turns a hung slave into a WB error.
//  Ports    : i_clk, i_axi_reset_n (async, active-low)
//             wb  : WB slave side   (cyc/stb/we/addr/wdata/sel, stall/ack/err/rdata)
//             axi : AXI-lite master (AW/W/B/AR/R channels)
//  Revision : 1.0  initial release
// ============================================================================
module wbsp2axil
    import axil_wb_pkg::*;
#(
    parameter int         C_AXI_DATA_WIDTH = 32,
    parameter int         C_AXI_ADDR_WIDTH = 28,
    parameter int         WB_DATA_WIDTH    = 8,
    parameter int         GRANULARITY      = 8,
    parameter int         TIMEOUT_CYCLES   = 10,
    parameter logic [2:0] AXI_PROT         = 3'b000
) (
    input  wire logic         i_clk,
    input  wire logic         i_axi_reset_n,
    wbsp2axil_wb_if.slave     wb,
    wbsp2axil_axil_if.master  axi
);
    localparam int c_WB_SHIFT = CLOG2(WB_DATA_WIDTH / 8);
    localparam int c_LANE_W   = CLOG2(C_AXI_DATA_WIDTH / 8);
    localparam int c_STRB_W   = C_AXI_DATA_WIDTH / 8;
    localparam int c_SEL_W    = WB_DATA_WIDTH / GRANULARITY;
    localparam int c_AW       = C_AXI_ADDR_WIDTH - c_WB_SHIFT;

    wbsp2axil_state_t             r_state;
    logic                         r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [C_AXI_ADDR_WIDTH-1:0]  r_addr;
    logic [C_AXI_DATA_WIDTH-1:0]  r_wdata;
    logic [c_STRB_W-1:0]          r_wstrb;
    logic [c_LANE_W-1:0]          r_lane;
    logic                         r_stall, r_ack, r_err;
    logic [WB_DATA_WIDTH-1:0]     r_rdata;
    logic [C_TIMER_WIDTH-1:0]     r_cnt;
    logic                         r_drop, r_abort;

    logic [c_AW-1:0]              w_wb_addr;
    logic [C_AXI_ADDR_WIDTH-1:0]  w_byte_addr;
    logic [c_LANE_W-1:0]          w_lane;
    logic [C_AXI_DATA_WIDTH-1:0]  w_axi_wdata;
    logic [c_STRB_W-1:0]          w_axi_wstrb;
    logic [WB_DATA_WIDTH-1:0]     w_wb_rdata;
    logic                         w_accept, w_busy, w_b_done, w_r_done, w_done;
    logic                         w_drop_eff, w_cyc_live, w_timeout, w_is_err;
    logic [C_TIMER_WIDTH-1:0]     w_cnt_next;
    axi_resp_t                    w_resp;

    assign w_wb_addr   = wb.addr;
    assign w_byte_addr = C_AXI_ADDR_WIDTH'(w_wb_addr) << c_WB_SHIFT;
    assign w_lane      = w_byte_addr[c_LANE_W-1:0];

    wbsp2axil_lane #(
        .AXI_DW (C_AXI_DATA_WIDTH),
        .WB_DW  (WB_DATA_WIDTH),
        .SEL_W  (c_SEL_W),
        .LANE_W (c_LANE_W)
    ) u_lane (
        .wr_lane   (w_lane),
        .wb_wdata  (wb.wdata),
        .wb_sel    (wb.sel),
        .axi_wdata (w_axi_wdata),
        .axi_wstrb (w_axi_wstrb),
        .rd_lane   (r_lane),
        .axi_rdata (axi.rdata),
        .wb_rdata  (w_wb_rdata)
    );

    // Stall stays high through the ack/err cycle, so IDLE only accepts once
    // it has been cleared again.
    assign w_accept   = (r_state == ST_IDLE) && !r_stall && wb.cyc && wb.stb;
    assign w_busy     = (r_state != ST_IDLE) || w_accept;
    assign w_b_done   = (r_state == ST_WB_RESP) && r_bready && axi.bvalid;
    assign w_r_done   = (r_state == ST_RD_RESP) && r_rready && axi.rvalid;
    assign w_done     = w_b_done || w_r_done;
    assign w_resp     = axi_resp_t'(w_b_done ? axi.bresp : axi.rresp);
    assign w_is_err   = (w_resp == SLVERR) || (w_resp == DECERR);

    // Flags belonging to the previous transaction must not leak into the
    // cycle that accepts a new one.
    assign w_drop_eff = w_accept ? 1'b0 : r_drop;
    assign w_cyc_live = wb.cyc && (w_accept || !r_abort);

    // Counter value equals the number of cycles elapsed since accept.
    assign w_cnt_next = w_accept ? C_TIMER_WIDTH'(1)
                      : (r_cnt == {C_TIMER_WIDTH{1'b1}}) ? r_cnt
                      : r_cnt + C_TIMER_WIDTH'(1);
    assign w_timeout  = w_busy && !w_drop_eff && !w_done && (TIMEOUT_CYCLES != 0)
                        && (int'(w_cnt_next) == TIMEOUT_CYCLES);

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_lane    <= '0;
            r_stall   <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_drop    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_busy) begin
                r_cnt <= w_cnt_next;
            end
            if ((r_state != ST_IDLE) && !wb.cyc) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_stall) begin
                        r_stall <= 1'b0;
                    end else if (w_accept) begin
                        r_stall <= 1'b1;
                        r_drop  <= 1'b0;
                        r_abort <= 1'b0;
                        r_addr  <= {w_byte_addr[C_AXI_ADDR_WIDTH-1:c_LANE_W], c_LANE_W'(0)};
                        r_lane  <= w_lane;
                        if (wb.we) begin
                            r_state   <= ST_WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_wdata   <= w_axi_wdata;
                            r_wstrb   <= w_axi_wstrb;
                        end else begin
                            r_state   <= ST_RD;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (axi.awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (axi.wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if ((!r_awvalid || axi.awready) && (!r_wvalid || axi.wready)) begin
                        r_state  <= ST_WB_RESP;
                        r_bready <= 1'b1;
                    end
                end
                ST_WB_RESP: begin
                    if (w_b_done) begin
                        r_bready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (w_r_done) begin
                        r_rready <= 1'b0;
                        r_state  <= ST_IDLE;
                        if (!r_drop) begin
                            r_rdata <= w_wb_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A response that arrives after a timeout was already reported
            // is consumed silently; an abandoned WB cycle gets nothing.
            if (w_done && !r_drop && w_cyc_live) begin
                r_ack <= !w_is_err;
                r_err <= w_is_err;
            end
            if (w_timeout) begin
                r_drop <= 1'b1;
                if (w_cyc_live) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign wb.stall    = r_stall;
    assign wb.ack      = r_ack;
    assign wb.err      = r_err;
    assign wb.rdata    = r_rdata;

    assign axi.awvalid = r_awvalid;
    assign axi.awaddr  = r_addr;
    assign axi.awprot  = AXI_PROT;
    assign axi.wvalid  = r_wvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.bready  = r_bready;
    assign axi.arvalid = r_arvalid;
    assign axi.araddr  = r_addr;
    assign axi.arprot  = AXI_PROT;
    assign axi.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_wbsp2axil.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wbsp2axil
//  Purpose  : Directed self-checking bench for wbsp2axil (32-bit AXI, 8-bit WB,
//             timeout 10). Expected WB responses are queued when a request is
//             issued and popped whenever ack/err is observed.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wbsp2axil;
    import axil_wb_pkg::*;

    localparam int AXW = 32;
    localparam int AAW = 28;
    localparam int WDW = 8;

    typedef struct {
        logic       ack;
        logic       err;
        logic       chk;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wbsp2axil_wb_if   #(.AW(AAW), .DW(WDW)) wb ();
    wbsp2axil_axil_if #(.AW(AAW), .DW(AXW)) axi ();

    wbsp2axil #(
        .C_AXI_DATA_WIDTH (AXW),
        .C_AXI_ADDR_WIDTH (AAW),
        .WB_DATA_WIDTH    (WDW),
        .GRANULARITY      (8),
        .TIMEOUT_CYCLES   (10),
        .AXI_PROT         (3'b000)
    ) dut (
        .i_clk         (clk),
        .i_axi_reset_n (rst_n),
        .wb            (wb),
        .axi           (axi)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;
    int   resp_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any WB response seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc_no++;
        if (wb.ack || wb.err) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {30'd0, wb.ack, wb.err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_ack", wb.ack, e.ack);
                check("resp_err", wb.err, e.err);
                if (e.chk) check("resp_rdata", wb.rdata, e.data);
                resp_cyc = cyc_no;
            end
        end
    endtask

    function automatic logic [27:0] exp_aligned(input logic [27:0] a);
        return a & ~28'h3;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [27:0] a, input logic sel);
        logic [1:0] ln;
        ln = a[1:0];
        return {3'b000, sel} << ln;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] d, input logic [27:0] a);
        logic [1:0] ln;
        ln = a[1:0];
        return 8'(d >> (8 * ln));
    endfunction

    // Present a request and hold stb until it is taken; reports the falling
    // edge preceding the accepting clock and the number of stalled cycles.
    task automatic issue(input logic we, input logic [27:0] addr, input logic [7:0] data,
                         input logic sel, output int acc_cyc, output int waits);
        logic s;
        logic taken;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
        wb.addr = addr; wb.wdata = data; wb.sel = sel;
        waits = 0; acc_cyc = 0; taken = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s = wb.stall;
            acc_cyc = cyc_no;
            tick();
            if (!s) begin
                taken = 1'b1;
                break;
            end
            waits++;
        end
        wb.stb = 1'b0;
        check("request_taken", taken, 1'b1);
    endtask

    task automatic axi_wr(input logic [27:0] e_addr, input logic [31:0] e_data, input logic [3:0] e_strb,
                          input int aw_d, input int w_d, input int b_d, input logic [1:0] resp);
        int n;
        n = (aw_d > w_d) ? aw_d : w_d;
        check("awvalid_up", axi.awvalid, 1'b1);
        check("wvalid_up", axi.wvalid, 1'b1);
        check("awaddr", axi.awaddr, e_addr);
        check("wdata", axi.wdata, e_data);
        check("wstrb", axi.wstrb, e_strb);
        for (int c = 0; c <= n; c++) begin
            if (c > 0) begin
                check("awvalid_hold", axi.awvalid, c <= aw_d);
                check("wvalid_hold", axi.wvalid, c <= w_d);
            end
            axi.awready = (c == aw_d);
            axi.wready  = (c == w_d);
            tick();
        end
        axi.awready = 1'b0;
        axi.wready = 1'b0;
        check("aw_w_dropped", {axi.awvalid, axi.wvalid}, 2'b00);
        for (int c = 0; c < b_d; c++) begin
            check("bready_wait", axi.bready, 1'b1);
            tick();
        end
        check("bready", axi.bready, 1'b1);
        axi.bvalid = 1'b1; axi.bresp = resp;
        tick();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        check("bready_drop", axi.bready, 1'b0);
    endtask

    task automatic axi_rd(input logic [27:0] e_addr, input int ar_d, input int r_d,
                          input logic [31:0] data, input logic [1:0] resp, input logic abort);
        check("arvalid_up", axi.arvalid, 1'b1);
        check("araddr", axi.araddr, e_addr);
        for (int c = 0; c <= ar_d; c++) begin
            if (c > 0) check("arvalid_hold", axi.arvalid, 1'b1);
            check("stall_busy_ar", wb.stall, 1'b1);
            axi.arready = (c == ar_d);
            tick();
        end
        axi.arready = 1'b0;
        check("arvalid_drop", axi.arvalid, 1'b0);
        if (abort) wb.cyc = 1'b0;
        for (int c = 0; c < r_d; c++) begin
            check("rready_wait", axi.rready, 1'b1);
            check("stall_busy_r", wb.stall, 1'b1);
            tick();
        end
        check("rready", axi.rready, 1'b1);
        axi.rvalid = 1'b1; axi.rdata = data; axi.rresp = resp;
        tick();
        axi.rvalid = 1'b0; axi.rresp = 2'b00;
        check("rready_drop", axi.rready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int w;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.addr = '0; wb.wdata = '0; wb.sel = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;

        // reset state
        tick(); tick();
        check("rst_stall", wb.stall, 1'b0);
        check("rst_ack_err", {wb.ack, wb.err}, 2'b00);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
        check("rst_readies", {axi.bready, axi.rready}, 2'b00);
        check("rst_rdata", wb.rdata, 8'h00);
        rst_n = 1'b1;
        tick();

        // zero-wait write, lane 3
        sb.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        issue(1'b1, 28'h0000003, 8'hA5, 1'b1, acc, w);
        axi_wr(exp_aligned(28'h3), 32'hA5A5A5A5, exp_strb(28'h3, 1'b1), 0, 0, 0, OKAY);
        check("wr_latency", resp_cyc - acc, 3);
        check("stall_in_ack", wb.stall, 1'b1);

        // read issued during the ack cycle: stalled exactly one cycle
        sb.push_back('{1'b1, 1'b0, 1'b1, exp_byte(32'h11223344, 28'h6)});
        issue(1'b0, 28'h0000006, 8'h00, 1'b0, acc, w);
        check("stall_after_ack", w, 1);
        axi_rd(exp_aligned(28'h6), 0, 0, 32'h11223344, OKAY, 1'b0);
        check("rd_latency", resp_cyc - acc, 3);
        check("rd_byte", wb.rdata, 8'h22);
        tick();
        check("sb_empty_rd", sb.size(), 0);

        // delayed read, EXOKAY, top lane
        sb.push_back('{1'b1, 1'b0, 1'b1, exp_byte(32'hDEADBEEF, 28'h7)});
        issue(1'b0, 28'h0000007, 8'h00, 1'b0, acc, w);
        axi_rd(exp_aligned(28'h7), 2, 1, 32'hDEADBEEF, EXOKAY, 1'b0);
        tick();

        // read SLVERR
        sb.push_back('{1'b0, 1'b1, 1'b0, 8'h00});
        issue(1'b0, 28'h0000001, 8'h00, 1'b0, acc, w);
        axi_rd(exp_aligned(28'h1), 0, 0, 32'h0BADF00D, SLVERR, 1'b0);
        tick();

        // write DECERR
        sb.push_back('{1'b0, 1'b1, 1'b0, 8'h00});
        issue(1'b1, 28'h0000002, 8'h5A, 1'b1, acc, w);
        axi_wr(exp_aligned(28'h2), 32'h5A5A5A5A, exp_strb(28'h2, 1'b1), 0, 0, 0, DECERR);
        tick();

        // backpressure: awready three cycles ahead of wready
        sb.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        issue(1'b1, 28'h0000010, 8'h3C, 1'b1, acc, w);
        axi_wr(exp_aligned(28'h10), 32'h3C3C3C3C, exp_strb(28'h10, 1'b1), 0, 3, 1, OKAY);
        tick();

        // all-zero select still writes, with empty strobes
        sb.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        issue(1'b1, 28'h0000005, 8'h77, 1'b0, acc, w);
        axi_wr(exp_aligned(28'h5), 32'h77777777, 4'b0000, 0, 0, 0, OKAY);
        tick();
        check("sb_empty_mid", sb.size(), 0);

        // timeout: B held back 20 cycles
        sb.push_back('{1'b0, 1'b1, 1'b0, 8'h00});
        issue(1'b1, 28'h0000008, 8'h99, 1'b1, acc, w);
        axi_wr(exp_aligned(28'h8), 32'h99999999, exp_strb(28'h8, 1'b1), 0, 0, 20, OKAY);
        check("timeout_cycle", resp_cyc - acc, 10);
        sb.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        issue(1'b1, 28'h0000009, 8'h12, 1'b1, acc, w);
        check("after_timeout_wait", w, 1);
        axi_wr(exp_aligned(28'h9), 32'h12121212, exp_strb(28'h9, 1'b1), 0, 0, 0, OKAY);
        tick();

        // abort: cyc dropped while waiting for R, no response expected
        issue(1'b0, 28'h0000009, 8'h00, 1'b0, acc, w);
        axi_rd(exp_aligned(28'h9), 0, 2, 32'h55667788, OKAY, 1'b1);
        tick(); tick();
        sb.push_back('{1'b1, 1'b0, 1'b1, exp_byte(32'hCAFEF00D, 28'hA)});
        issue(1'b0, 28'h000000A, 8'h00, 1'b0, acc, w);
        axi_rd(exp_aligned(28'hA), 0, 0, 32'hCAFEF00D, OKAY, 1'b0);
        tick();
        check("sb_empty_abort", sb.size(), 0);

        // asynchronous reset while in WR
        issue(1'b1, 28'h0000004, 8'hEE, 1'b1, acc, w);
        check("wr_before_rst", axi.awvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
        check("arst_readies", {axi.bready, axi.rready}, 2'b00);
        check("arst_wb", {wb.stall, wb.ack, wb.err}, 3'b000);
        check("arst_addr", axi.awaddr, 28'h0);
        check("arst_wdata_strb", {axi.wdata, axi.wstrb}, 36'h0);
        check("arst_rdata", wb.rdata, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        sb.push_back('{1'b1, 1'b0, 1'b1, exp_byte(32'h000000AB, 28'h0)});
        issue(1'b0, 28'h0000000, 8'h00, 1'b0, acc, w);
        check("post_rst_wait", w, 0);
        axi_rd(exp_aligned(28'h0), 0, 0, 32'h000000AB, OKAY, 1'b0);
        tick(); tick();
        check("sb_empty_end", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
